// File: rtl/axi_wr_slave.sv
// AXI write-channel responder: accepts one burst at a time, buffers each beat
// with its computed address in a FIFO that the I2C transmit engine drains.
module axi_wr_slave #(
  parameter int ADDR_WIDTH     = 32,
  parameter int WDATA_WIDTH    = 32,
  parameter int SIZE           = 3,
  parameter int BURST_SIZE     = 2,
  parameter int RESPONSE_WIDTH = 2,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic [SIZE-1:0]           AWSIZE,
  input  logic [BURST_SIZE-1:0]     AWBURST,
  input  logic                      WVALID,
  output logic                      WREADY,
  input  logic                      WLAST,
  input  logic [WDATA_WIDTH-1:0]    WADATA,
  output logic                      BVALID,
  input  logic                      BREADY,
  output logic [RESPONSE_WIDTH-1:0] BRESP,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [ADDR_WIDTH-1:0]     tx_addr,
  output logic [WDATA_WIDTH-1:0]    tx_data,
  output logic                      tx_last,
  output logic                      busy
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = ADDR_WIDTH + WDATA_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0]   incr_q, incr_d;
  logic [BURST_SIZE-1:0]   burst_q, burst_d;
  logic                    err_q, err_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]          count_q, count_d;
  logic [ENTRY_W-1:0]      mem_q [FIFO_DEPTH];

  logic                    aw_hs, w_hs, b_hs, push, pop, fifo_full;
  logic [ADDR_WIDTH-1:0]   aw_bytes;
  logic [ENTRY_W-1:0]      head;

  assign aw_bytes  = ADDR_WIDTH'(1) << AWSIZE;
  assign fifo_full = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign aw_hs     = AWVALID & AWREADY;
  assign w_hs      = WVALID & WREADY;
  assign b_hs      = BVALID & BREADY;
  assign push      = w_hs & ~err_q;
  assign tx_valid  = (count_q != '0);
  assign pop       = tx_valid & tx_ready;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (aw_hs)         state_d = S_DATA;
      S_DATA:  if (w_hs && WLAST) state_d = S_RESP;
      S_RESP:  if (b_hs)          state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // Handshake outputs depend on registered state and count only.
  always_comb begin
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    BRESP   = '0;
    busy    = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: AWREADY = 1'b1;
      S_DATA: WREADY  = err_q | ~fifo_full;
      S_RESP: begin
        BVALID = 1'b1;
        BRESP  = err_q ? RESPONSE_WIDTH'(2) : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    cur_addr_d = cur_addr_q;
    incr_d     = incr_q;
    burst_d    = burst_q;
    err_d      = err_q;
    if (aw_hs) begin
      cur_addr_d = AWADDR;
      incr_d     = aw_bytes;
      burst_d    = AWBURST;
      err_d      = (AWBURST >= BURST_SIZE'(2)) ||
                   (aw_bytes > ADDR_WIDTH'(WDATA_WIDTH / 8));
    end else if (w_hs && burst_q == BURST_SIZE'(1)) begin
      cur_addr_d = cur_addr_q + incr_q;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cur_addr_q <= '0;
      incr_q     <= '0;
      burst_q    <= '0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      cur_addr_q <= cur_addr_d;
      incr_q     <= incr_d;
      burst_q    <= burst_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by count_q alone.
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cur_addr_q, WADATA, WLAST};
    end
  end

  assign head    = mem_q[rd_ptr_q];
  assign tx_addr = head[ENTRY_W-1 -: ADDR_WIDTH];
  assign tx_data = head[WDATA_WIDTH:1];
  assign tx_last = head[0];

endmodule

// File: tb/tb_axi_wr_slave.sv
// Directed bench for axi_wr_slave with a queue-based scoreboard of expected
// FIFO beats and response codes derived from the burst parameters.
module tb_axi_wr_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        AWVALID, AWREADY;
  logic [31:0] AWADDR;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        WVALID, WREADY, WLAST;
  logic [31:0] WADATA;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;
  logic        tx_valid, tx_ready, tx_last;
  logic [31:0] tx_addr, tx_data;
  logic        busy;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic        l;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        log_q[$];
  logic [1:0]  exp_resp = 2'b00;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 ACLK = ~ACLK;

  axi_wr_slave #(
    .ADDR_WIDTH(32), .WDATA_WIDTH(32), .SIZE(3), .BURST_SIZE(2),
    .RESPONSE_WIDTH(2), .FIFO_DEPTH(8)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WADATA(WADATA),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_addr(tx_addr),
    .tx_data(tx_data), .tx_last(tx_last), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Scoreboard: every popped head must match the oldest expected beat.
  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (exp_q.size() == 0) begin
        chk("tx_valid_idle", tx_valid, 0);
      end else if (tx_valid && tx_ready) begin
        ent_t e;
        e = exp_q.pop_front();
        chk("tx_addr", tx_addr, e.a);
        chk("tx_data", tx_data, e.d);
        chk("tx_last", tx_last, e.l);
        log_q.push_back('{a: tx_addr, d: tx_data, l: tx_last});
      end
      if (BVALID) chk("bresp", BRESP, exp_resp);
    end
  end

  // Model: beat i of an accepted burst lands at start + i*2**size (INCR) or
  // start (FIXED); WRAP/reserved or oversized beats produce no entries.
  task automatic aw(input logic [31:0] addr, input logic [2:0] size,
                    input logic [1:0] burst, input int unsigned beats,
                    input logic [31:0] dbase);
    int unsigned bytes, n;
    bit err;
    bytes = 1 << size;
    err = (burst >= 2) || (bytes > 4);
    exp_resp = err ? 2'b10 : 2'b00;
    if (!err) begin
      for (int unsigned i = 0; i < beats; i++) begin
        exp_q.push_back('{a: (burst == 2'b01) ? addr + i * bytes : addr,
                          d: dbase + i, l: (i == beats - 1)});
      end
    end
    AWVALID = 1'b1; AWADDR = addr; AWSIZE = size; AWBURST = burst;
    n = 0;
    while (!AWREADY && n < 100) begin step(); n++; end
    if (n >= 100) timeout("awready");
    step();
    AWVALID = 1'b0;
    chk("aw_to_wready", WREADY, 1);
    chk("busy_data", busy, 1);
    chk("awready_data", AWREADY, 0);
  endtask

  task automatic beat(input logic [31:0] data, input logic last);
    int unsigned n;
    WVALID = 1'b1; WADATA = data; WLAST = last;
    n = 0;
    while (!WREADY && n < 100) begin step(); n++; end
    if (n >= 100) timeout("wready");
    step();
    WVALID = 1'b0; WLAST = 1'b0;
    if (last) chk("wlast_to_bvalid", BVALID, 1);
  endtask

  task automatic resp();
    int unsigned n;
    n = 0;
    while (!BVALID && n < 100) begin step(); n++; end
    if (n >= 100) timeout("bvalid");
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    chk("bready_to_awready", AWREADY, 1);
    chk("bvalid_clear", BVALID, 0);
  endtask

  task automatic wr_burst(input logic [31:0] addr, input logic [2:0] size,
                          input logic [1:0] burst, input int unsigned beats,
                          input logic [31:0] dbase);
    aw(addr, size, burst, beats, dbase);
    for (int unsigned i = 0; i < beats; i++) beat(dbase + i, i == beats - 1);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (tx_valid && n < 100) begin step(); n++; end
    if (n >= 100) timeout("drain");
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    ARESETn = 1'b0; AWVALID = 1'b0; AWADDR = '0; AWSIZE = '0; AWBURST = '0;
    WVALID = 1'b0; WLAST = 1'b0; WADATA = '0; BREADY = 1'b0; tx_ready = 1'b0;
    repeat (3) step();
    ARESETn = 1'b1;
    step();
    chk("rst_awready", AWREADY, 1);
    chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_bresp", BRESP, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);

    // INCR, 4 beats of 4 bytes
    tx_ready = 1'b1;
    log_q.delete();
    wr_burst(32'h1000, 3'd2, 2'b01, 4, 32'hA0);
    chk("incr_bresp", BRESP, 2'b00);
    resp();
    drain();
    chk("incr_log_n", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("incr_b0", log_q[0], {32'h1000, 32'hA0, 1'b0});
      chk("incr_b2", log_q[2], {32'h1008, 32'hA2, 1'b0});
      chk("incr_b3", log_q[3], {32'h100C, 32'hA3, 1'b1});
    end

    // FIXED, byte beats
    log_q.delete();
    wr_burst(32'h20, 3'd0, 2'b00, 3, 32'h55);
    resp();
    drain();
    chk("fixed_log_n", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("fixed_b1", log_q[1], {32'h20, 32'h56, 1'b0});
      chk("fixed_b2", log_q[2], {32'h20, 32'h57, 1'b1});
    end

    // Errors: WRAP burst, then 8-byte beats on a 32-bit bus
    log_q.delete();
    wr_burst(32'h40, 3'd2, 2'b10, 2, 32'hC0);
    chk("wrap_bresp", BRESP, 2'b10);
    resp();
    wr_burst(32'h80, 3'd3, 2'b01, 2, 32'hD0);
    chk("size_bresp", BRESP, 2'b10);
    resp();
    chk("err_no_tx", log_q.size(), 0);

    // Back-pressure: 10 beats into an 8-deep FIFO
    tx_ready = 1'b0;
    log_q.delete();
    aw(32'h3000, 3'd2, 2'b01, 10, 32'hB0);
    for (int unsigned i = 0; i < 8; i++) beat(32'hB0 + i, 1'b0);
    chk("full_wready", WREADY, 0);
    WVALID = 1'b1; WADATA = 32'hB8; WLAST = 1'b0;
    step();
    chk("full_wready_hold", WREADY, 0);
    tx_ready = 1'b1;
    chk("pop_same_cycle", WREADY, 0);
    step();
    tx_ready = 1'b0;
    chk("pop_next_cycle", WREADY, 1);
    beat(32'hB8, 1'b0);
    tx_ready = 1'b1;
    beat(32'hB9, 1'b1);
    resp();
    drain();
    chk("bp_log_n", log_q.size(), 10);
    if (log_q.size() == 10) begin
      chk("bp_b8", log_q[8], {32'h3020, 32'hB8, 1'b0});
      chk("bp_b9", log_q[9], {32'h3024, 32'hB9, 1'b1});
    end

    // Response held off; a second request must wait
    wr_burst(32'h40, 3'd2, 2'b01, 1, 32'h11);
    AWVALID = 1'b1; AWADDR = 32'h50; AWSIZE = 3'd2; AWBURST = 2'b01;
    for (int unsigned i = 0; i < 5; i++) begin
      chk("hold_bvalid", BVALID, 1);
      chk("hold_bresp", BRESP, 2'b00);
      chk("hold_awready", AWREADY, 0);
      chk("hold_wready", WREADY, 0);
      step();
    end
    resp();
    wr_burst(32'h50, 3'd2, 2'b01, 2, 32'h22);
    resp();
    drain();

    // Reset in the middle of a burst
    tx_ready = 1'b0;
    aw(32'h60, 3'd2, 2'b01, 4, 32'h30);
    beat(32'h30, 1'b0);
    beat(32'h31, 1'b0);
    chk("pre_rst_tx_valid", tx_valid, 1);
    ARESETn = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_bvalid", BVALID, 0);
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_busy", busy, 0);
    step();
    ARESETn = 1'b1;
    step();
    chk("post_rst_awready", AWREADY, 1);
    tx_ready = 1'b1;
    log_q.delete();
    wr_burst(32'h70, 3'd1, 2'b01, 2, 32'h44);
    resp();
    drain();
    chk("post_rst_log_n", log_q.size(), 2);
    if (log_q.size() == 2) chk("post_rst_b1", log_q[1], {32'h72, 32'h45, 1'b1});

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_wr_slave.md
Name: axi_wr_slave

Overview:
- AXI write-channel responder: the slave end of the bridge's AXI write channels (write request, write data, write response).
- Accepts one write burst at a time.
- Buffers each accepted data beat, with its computed beat address, in an internal FIFO.
- The I2C transmit engine pops the FIFO through a valid/ready port. Each burst completes with a write response.

Parameters:
- ADDR_WIDTH, 32, AWADDR and beat-address width
- WDATA_WIDTH, 32, WADATA width; must be 8, 16, 32 or 64
- SIZE, 3, AWSIZE width
- BURST_SIZE, 2, AWBURST width
- RESPONSE_WIDTH, 2, BRESP width
- FIFO_DEPTH, 8, beat FIFO entries; power of two, at least 2

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESETn  in  1  asynchronous active-low reset
- AWVALID  in  1  write-request valid
- AWREADY  out  1  write-request ready
- AWADDR  in  ADDR_WIDTH  burst start address
- AWSIZE  in  SIZE  bytes per beat = 2**AWSIZE
- AWBURST  in  BURST_SIZE  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- WVALID  in  1  write-data valid
- WREADY  out  1  write-data ready
- WLAST  in  1  final beat of burst
- WADATA  in  WDATA_WIDTH  write data
- BVALID  out  1  response valid
- BREADY  in  1  response ready
- BRESP  out  RESPONSE_WIDTH  00 OKAY, 10 SLVERR
- tx_valid  out  1  FIFO head valid (FIFO not empty)
- tx_ready  in  1  I2C engine pops head
- tx_addr  out  ADDR_WIDTH  beat address of head
- tx_data  out  WDATA_WIDTH  beat data of head
- tx_last  out  1  head is last beat of its burst
- busy  out  1  state != IDLE

Behaviour:
- Reset (ARESETn low, asynchronous):
  - State goes to IDLE; FIFO is emptied.
  - BVALID=0, BRESP=00, WREADY=0, AWREADY=1 after reset release, tx_valid=0, busy=0.
  - Reset mid-burst or mid-response discards the burst. No response is issued and popped beats are not recalled.
- State machine, registered states IDLE, DATA, RESP:
  - IDLE: AWREADY=1. On AWVALID&AWREADY:
    - Latch AWADDR into cur_addr.
    - Latch 2**AWSIZE into incr.
    - Latch AWBURST.
    - Compute err = (AWBURST>=2) | (2**AWSIZE > WDATA_WIDTH/8).
    - Go to DATA. AWREADY=0 outside IDLE.
  - DATA: WREADY = err | !fifo_full, where fifo_full is a registered count. On WVALID&WREADY:
    - If !err, push {cur_addr, WADATA, WLAST}.
    - If burst is INCR, cur_addr += incr, wrapping modulo 2**ADDR_WIDTH. FIXED leaves cur_addr unchanged.
    - If WLAST, go to RESP.
  - Erroneous bursts are drained: every beat is accepted and none is pushed.
  - RESP: BVALID=1, BRESP = err ? 10 : 00. BVALID and BRESP hold stable until BREADY. On BVALID&BREADY go to IDLE.
- Latency:
  - AW handshake to first WREADY: 1 cycle.
  - WLAST handshake to BVALID: 1 cycle.
  - BREADY handshake to AWREADY: 1 cycle.
  - Minimum single-beat burst: 3 cycles.
- The response does not wait for the FIFO to drain; tx_last marks burst boundaries for the I2C engine.
- FIFO:
  - Pop when tx_valid & tx_ready.
  - Simultaneous push and pop: count unchanged, ordering preserved.
  - A pop while full does not raise WREADY in the same cycle; WREADY rises the next cycle.
  - Pop while empty is ignored.
  - tx_* are undefined when tx_valid=0.
  - Pointers wrap at FIFO_DEPTH.
- Handshakes:
  - WVALID in IDLE or RESP is not accepted (WREADY=0).
  - AWVALID outside IDLE waits.
  - Outputs never depend combinationally on the same-cycle VALID or READY inputs, except through registered state.

Test Plan:
- INCR, AWADDR=0x1000, AWSIZE=2, 4 beats 0xA0..0xA3 with WLAST on beat 4, tx_ready=1 -> tx entries (0x1000,0xA0,0), (0x1004,0xA1,0), (0x1008,0xA2,0), (0x100C,0xA3,1); BVALID one cycle after WLAST with BRESP=00.
- FIXED, AWADDR=0x20, AWSIZE=0, 3 beats -> all tx_addr=0x20, tx_last only on the third beat, BRESP=00.
- Error cases: AWBURST=10 with 2 beats, or AWSIZE=3 with WDATA_WIDTH=32 -> all beats accepted, tx_valid stays 0, BRESP=10.
- tx_ready=0 with a 10-beat INCR burst, FIFO_DEPTH=8 -> WREADY drops after 8 pushes. Raising tx_ready for one pop gives WREADY=1 the next cycle. All 10 beats are delivered in order, then BRESP=00.
- BREADY held 0 for 5 cycles -> BVALID and BRESP stable, AWREADY=0 throughout, a second AWVALID waits. After BREADY, AWREADY=1 one cycle later.
- ARESETn pulsed low after beat 2 of a 4-beat burst -> immediately BVALID=0, tx_valid=0, busy=0. After release AWREADY=1 and a fresh burst completes normally.
